// File: rtl/byte_striping_if.sv
// Handshake bundle for the transmit-side byte striping stage.
// The striper drives the lane group and in_ready through the master view.
// The upstream/downstream environment drives the byte stream and lane_ready
// through the slave view.
interface byte_striping_if;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] Lane_0;
    logic [7:0] Lane_1;
    logic [7:0] Lane_2;
    logic [7:0] Lane_3;
    logic       lane_valid;
    logic       lane_ready;
    logic [2:0] lane_count;
    logic [1:0] ctr_3;

    modport master (
        input  data_in, in_valid, flush, lane_ready,
        output in_ready, Lane_0, Lane_1, Lane_2, Lane_3,
        output lane_valid, lane_count, ctr_3
    );

    modport slave (
        output data_in, in_valid, flush, lane_ready,
        input  in_ready, Lane_0, Lane_1, Lane_2, Lane_3,
        input  lane_valid, lane_count, ctr_3
    );
endinterface

// File: rtl/byte_striping.sv
// Transmit-side byte striping stage for the four-lane link.
// Bytes are collected round-robin into a four-slot staging buffer (first byte
// of a group lands in slot 0 / Lane_0). A completed or flushed group is moved
// into the registered lane outputs when the output register is free, so up to
// one group can wait in staging while another is presented downstream.
module byte_striping #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic            clk250k,
    input  logic            reset,
    byte_striping_if.master bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] stage [4];
    logic [7:0] stage_next [4];
    logic [1:0] cnt;
    logic [1:0] cnt_next;
    logic [2:0] stage_count;
    logic [2:0] stage_count_next;
    logic [2:0] fill_level;
    logic       stage_full;
    logic       out_free;
    logic       accept;
    logic       transfer;

    // Handshake decode; in_ready depends combinationally on lane_ready so the
    // staging slot freed by a transfer can be refilled in the same cycle.
    assign stage_full   = (state == FULL);
    assign out_free     = !bus.lane_valid || bus.lane_ready;
    assign bus.in_ready = !reset && (!stage_full || out_free);
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = stage_full && out_free;
    assign fill_level   = {1'b0, cnt} + {2'b00, accept};
    assign bus.ctr_3    = cnt;

    // Next-state logic: fill slots, complete or flush a group, hand it off.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        stage_count_next = stage_count;
        for (int k = 0; k < 4; k++) begin
            stage_next[k] = stage[k];
        end
        case (state)
            FILL: begin
                if (accept) begin
                    stage_next[cnt] = bus.data_in;
                end
                if (fill_level == 3'd4) begin
                    state_next       = FULL;
                    stage_count_next = 3'd4;
                end else if (bus.flush && (fill_level != 3'd0)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (3'(k) >= fill_level) begin
                            stage_next[k] = PAD_BYTE;
                        end
                    end
                    stage_count_next = fill_level;
                    cnt_next         = fill_level[1:0];
                    state_next       = FULL;
                end else if (accept) begin
                    cnt_next = cnt + 2'd1;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_next = FILL;
                    cnt_next   = 2'd0;
                    if (accept) begin
                        stage_next[0] = bus.data_in;
                        cnt_next      = 2'd1;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Staging buffer, slot counter and FSM state registers.
    always_ff @(posedge clk250k or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            cnt         <= 2'd0;
            stage_count <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                stage[k] <= 8'h00;
            end
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            stage_count <= stage_count_next;
            for (int k = 0; k < 4; k++) begin
                stage[k] <= stage_next[k];
            end
        end
    end

    // Output register: load on transfer, otherwise hold until downstream takes it.
    always_ff @(posedge clk250k or posedge reset) begin
        if (reset) begin
            bus.Lane_0     <= 8'h00;
            bus.Lane_1     <= 8'h00;
            bus.Lane_2     <= 8'h00;
            bus.Lane_3     <= 8'h00;
            bus.lane_count <= 3'd0;
            bus.lane_valid <= 1'b0;
        end else if (transfer) begin
            bus.Lane_0     <= stage[0];
            bus.Lane_1     <= stage[1];
            bus.Lane_2     <= stage[2];
            bus.Lane_3     <= stage[3];
            bus.lane_count <= stage_count;
            bus.lane_valid <= 1'b1;
        end else if (bus.lane_ready) begin
            bus.lane_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_striping.sv
// Self-checking bench for byte_striping: a byte-level reference model closes
// groups into a queue as bytes are accepted, and a monitor pops and compares
// each group when the DUT hands it downstream.
module tb_byte_striping;

    logic clk250k = 1'b0;
    logic reset;

    byte_striping_if bus ();

    byte_striping #(.PAD_BYTE(8'h00)) dut (
        .clk250k (clk250k),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk250k = ~clk250k;

    int          compareCount  = 0;
    int          mismatchCount = 0;
    int          stall_cycles  = 0;
    logic [34:0] expected_q [$];
    logic [7:0]  model_grp [$];
    logic [34:0] exp_grp;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Close the model's current group: pad unused slots and queue it.
    task automatic closeGroup();
        int         n;
        logic [7:0] l [4];
        n = model_grp.size();
        for (int k = 0; k < 4; k++) begin
            l[k] = (k < n) ? model_grp[k] : 8'h00;
        end
        expected_q.push_back({3'(n), l[0], l[1], l[2], l[3]});
        model_grp.delete();
    endtask

    // Offer one byte (optionally with flush) until it is accepted, bounded.
    task automatic applyStimulus(input logic [7:0] value, input logic with_flush);
        int waited = 0;
        bit done = 0;
        bus.data_in  = value;
        bus.in_valid = 1'b1;
        bus.flush    = with_flush;
        while (!done) begin
            @(negedge clk250k);
            if (bus.in_ready) begin
                @(posedge clk250k);
                #1;
                done = 1;
                model_grp.push_back(value);
                if (model_grp.size() == 4 || with_flush) closeGroup();
            end else begin
                stall_cycles++;
                waited++;
                if (waited > 40) begin
                    checkOutput("in_ready_timeout", 64'd0, 64'd1);
                    done = 1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // Flush alone for one cycle.
    task automatic applyFlush();
        bus.flush = 1'b1;
        @(posedge clk250k);
        #1;
        bus.flush = 1'b0;
        if (model_grp.size() > 0) closeGroup();
    endtask

    // Wait (bounded) until every expected group has been taken downstream.
    task automatic waitDrain();
        int n = 0;
        while (expected_q.size() > 0 && n < 40) begin
            @(posedge clk250k);
            #1;
            n++;
        end
        checkOutput("drain", 64'(expected_q.size()), 64'd0);
        @(posedge clk250k);
        #1;
    endtask

    // Scoreboard side: compare each group as it is handed downstream.
    always @(negedge clk250k) begin
        if (!reset && bus.lane_valid && bus.lane_ready) begin
            if (expected_q.size() == 0) begin
                checkOutput("unexpected_group", {29'd0, bus.lane_count, bus.Lane_0, bus.Lane_1, bus.Lane_2, bus.Lane_3}, 64'd0);
            end else begin
                exp_grp = expected_q.pop_front();
                checkOutput("group", {bus.lane_count, bus.Lane_0, bus.Lane_1, bus.Lane_2, bus.Lane_3}, exp_grp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.data_in    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.lane_ready = 1'b0;
        @(posedge clk250k);
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 1'b0);
        checkOutput("rst_lanes", {bus.Lane_0, bus.Lane_1, bus.Lane_2, bus.Lane_3}, 32'h0);
        checkOutput("rst_lane_valid", bus.lane_valid, 1'b0);
        checkOutput("rst_lane_count", bus.lane_count, 3'd0);
        checkOutput("rst_ctr_3", bus.ctr_3, 2'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1'b1);

        // Single group with output free: one-cycle latency, one-cycle valid.
        bus.lane_ready = 1'b1;
        applyStimulus(8'h11, 1'b0);
        checkOutput("ctr_after_1", bus.ctr_3, 2'd1);
        applyStimulus(8'h22, 1'b0);
        checkOutput("ctr_after_2", bus.ctr_3, 2'd2);
        applyStimulus(8'h33, 1'b0);
        checkOutput("ctr_after_3", bus.ctr_3, 2'd3);
        applyStimulus(8'h44, 1'b0);
        checkOutput("valid_before_xfer", bus.lane_valid, 1'b0);
        @(posedge clk250k);
        #1;
        checkOutput("valid_after_xfer", bus.lane_valid, 1'b1);
        checkOutput("ctr_wrap", bus.ctr_3, 2'd0);
        checkOutput("count_full", bus.lane_count, 3'd4);
        @(posedge clk250k);
        #1;
        checkOutput("valid_one_cycle", bus.lane_valid, 1'b0);
        waitDrain();

        // Continuous stream: never back-pressured, four groups.
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("stream_stalls", 64'(stall_cycles), 64'd0);
        waitDrain();

        // Backpressure: output and staging both fill, then release.
        bus.lane_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i), 1'b0);
        checkOutput("bp_in_ready", bus.in_ready, 1'b0);
        repeat (3) begin
            @(posedge clk250k);
            #1;
        end
        checkOutput("bp_hold_lanes", {bus.Lane_0, bus.Lane_1, bus.Lane_2, bus.Lane_3}, 32'h20212223);
        checkOutput("bp_hold_valid", bus.lane_valid, 1'b1);
        checkOutput("bp_still_blocked", bus.in_ready, 1'b0);
        bus.lane_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", bus.in_ready, 1'b1);
        waitDrain();

        // Partial flush with two bytes, then a flush on an empty group.
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b0);
        applyFlush();
        waitDrain();
        applyFlush();
        for (int i = 0; i < 3; i++) begin
            checkOutput("empty_flush_idle", bus.lane_valid, 1'b0);
            @(posedge clk250k);
            #1;
        end

        // Flush together with the third byte.
        applyStimulus(8'hC0, 1'b0);
        applyStimulus(8'hC1, 1'b0);
        applyStimulus(8'hB1, 1'b1);
        waitDrain();
        checkOutput("ctr_after_flush", bus.ctr_3, 2'd0);

        // Reset mid-group discards staged bytes.
        applyStimulus(8'hD1, 1'b0);
        applyStimulus(8'hD2, 1'b0);
        checkOutput("mid_ctr", bus.ctr_3, 2'd2);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ctr", bus.ctr_3, 2'd0);
        checkOutput("mid_rst_in_ready", bus.in_ready, 1'b0);
        model_grp.delete();
        expected_q.delete();
        @(posedge clk250k);
        #1;
        reset = 1'b0;

        // Reset while a group is presented discards it.
        bus.lane_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'hE1 + 8'(i), 1'b0);
        @(posedge clk250k);
        #1;
        checkOutput("held_valid", bus.lane_valid, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst_drop_valid", bus.lane_valid, 1'b0);
        checkOutput("rst_drop_lanes", {bus.Lane_0, bus.Lane_1, bus.Lane_2, bus.Lane_3}, 32'h0);
        checkOutput("rst_drop_count", bus.lane_count, 3'd0);
        model_grp.delete();
        expected_q.delete();
        @(posedge clk250k);
        #1;
        reset = 1'b0;
        bus.lane_ready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'hF1 + 8'(i), 1'b0);
        waitDrain();
        repeat (3) begin
            @(posedge clk250k);
            #1;
        end

        checkOutput("sb_empty", 64'(expected_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
